mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one parameter, MEM_LAT, default 1: memory read latency in cycles (legal 1..7).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Port clk  in  1  clock, all state on the rising edge.
REQ-003 Port reset  in  1  synchronous active-high reset.
REQ-004 Port req_read  in  1  load request from ctrl_unit, level, held until done or addr_err.
REQ-005 Port req_write  in  1  store request from ctrl_unit, level, same hold rule.
REQ-006 Port size  in  2  access size: 00 word, 01 half, 10 byte; 11 is illegal.
REQ-007 Port addr  in  32  byte address.
REQ-008 Port wdata  in  32  store data; half/byte taken from the low bits.
REQ-009 Port rdata  out  32  load result, sign-extended for half/byte, held until the next load completes.
REQ-010 Port done  out  1  one-cycle pulse when an access completes.
REQ-011 Port addr_err  out  1  one-cycle pulse when a request is misaligned or has an illegal size.
REQ-012 Port busy  out  1  high in every state except IDLE.
REQ-013 Port mem_addr  out  32  word address to memory, byte address with [1:0] forced to 00.
REQ-014 Port mem_wr  out  1  memory write strobe, one cycle.
REQ-015 Port mem_din  out  32  memory write data.
REQ-016 Port mem_dout  in  32  memory read data, valid MEM_LAT cycles after mem_addr is presented.

Function
REQ-017 The FSM SHALL use states IDLE, RD_WAIT, WR, RESP, ERR; all outputs SHALL be registered.
REQ-018 IDLE SHALL accept a request only in IDLE and latch addr, size, wdata and direction; input changes after acceptance SHALL be ignored.
REQ-019 If req_read and req_write are both high, the write SHALL take priority.
REQ-020 A request SHALL be flagged misaligned when size=01 with addr[0]=1, or size=00 with addr[1:0]≠00; size=11 is also an error. Such requests SHALL go IDLE->ERR->IDLE, pulse addr_err in ERR, leave memory untouched and not pulse done.
REQ-021 Read: IDLE->RD_WAIT; a 3-bit counter SHALL count MEM_LAT cycles; then go to RESP, capture rdata from mem_dout and pulse done.
REQ-022 With MEM_LAT=1, done SHALL rise exactly 3 cycles after the accepting edge.
REQ-023 Lane selection SHALL be little-endian: byte k is mem_dout[8k+7:8k]; the half at addr[1]=1 is bits 31:16.
REQ-024 Word write: IDLE->WR; mem_wr=1 with mem_din=wdata for one cycle; then RESP with a done pulse.
REQ-025 Half/byte write SHALL be read-modify-write: IDLE->RD_WAIT->WR, merging the wdata lane into the read word so other lanes are preserved, then RESP.
REQ-026 mem_wr SHALL be high only in WR.
REQ-027 RESP and ERR SHALL always return to IDLE.
REQ-028 If the request is still high in IDLE after done, it SHALL be re-accepted as a new access; the requester deasserts on done.
REQ-029 Counter wrap SHALL not occur: the counter SHALL be cleared on every RD_WAIT entry.

Reset
REQ-030 Reset SHALL, from any state including mid-access, force IDLE and counter=0, and set every output to 0 (rdata=0, done=0, addr_err=0, busy=0, mem_addr=0, mem_wr=0, mem_din=0) on the next edge.
REQ-031 No write SHALL be issued after a reset asserted during RD_WAIT of a read-modify-write.

Structure
REQ-032 Package mem_access_pkg SHALL hold the size encodings, the state encoding and the MEM_LAT default.
REQ-033 Lane extraction, sign-extension and merging SHALL live in one combinational sub-module, mem_lane_align.

Verification
REQ-034 Word load: memory[0x40]=0x8899AABB, read size=00 addr=0x40 -> done at cycle +3, rdata=0x8899AABB.
REQ-035 Byte load with sign: same word, size=10 addr=0x42 -> rdata=0xFFFFFF99; size=01 addr=0x40 -> rdata=0xFFFFAABB.
REQ-036 Byte store: memory[0x40]=0x11223344, write size=10 addr=0x41 wdata=0xAB -> one mem_wr with mem_din=0x1122AB44, then done.
REQ-037 Misalignment: write size=00 addr=0x42 -> addr_err pulse, mem_wr never 1, no done.
REQ-038 Reset in RD_WAIT of a half store -> no mem_wr, all outputs 0 next cycle; read+write both high -> write performed.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size and state encodings, default memory latency, alignment check.
package mem_access_pkg;
    localparam int MEM_LAT_DEF = 1;
    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR      = 3'd2,
        RESP    = 3'd3,
        ERR     = 3'd4
    } state_t;
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        return (sz == SZ_BAD) || (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extraction with sign extension, and store-lane merge.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] load,
    output logic [31:0] merged
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        load = size == SZ_BYTE ? {{24{b[7]}}, b} : size == SZ_HALF ? {{16{h[15]}}, h} : word;
        merged = word;
        if (size == SZ_BYTE)
            merged[{off, 3'b000} +: 8] = wdata[7:0];
        else if (size == SZ_HALF)
            merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer with alignment checks and read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        addr_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    state_t      state, state_d;
    logic [2:0]  cnt, cnt_d;
    logic [1:0]  off_q, off_d, sz_q, sz_d;
    logic [31:0] wd_q, wd_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_d, mem_addr_d, mem_din_d;
    logic        done_d, err_d;
    logic [31:0] lane_load, lane_merged;

    mem_lane_align u_align (
        .word   (mem_dout),
        .off    (off_q),
        .size   (sz_q),
        .wdata  (wd_q),
        .load   (lane_load),
        .merged (lane_merged)
    );

    // Outputs are registered from the next-state view, so busy/mem_wr track the state
    // they describe while done/addr_err appear on the edge leaving RESP/ERR.
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        off_d = off_q;
        sz_d = sz_q;
        wd_d = wd_q;
        wr_d = wr_q;
        rdata_d = rdata;
        mem_addr_d = mem_addr;
        mem_din_d = mem_din;
        done_d = 1'b0;
        err_d = 1'b0;
        unique case (state)
            IDLE: if (req_read || req_write) begin
                off_d = addr[1:0];
                sz_d = size;
                wd_d = wdata;
                wr_d = req_write;
                cnt_d = '0;
                mem_addr_d = {addr[31:2], 2'b00};
                mem_din_d = req_write ? wdata : mem_din;
                state_d = misaligned(size, addr[1:0]) ? ERR
                        : (req_write && size == SZ_WORD) ? WR : RD_WAIT;
            end
            RD_WAIT: if (cnt == 3'(MEM_LAT)) begin
                state_d = wr_q ? WR : RESP;
                mem_din_d = wr_q ? lane_merged : mem_din;
            end else begin
                cnt_d = cnt + 3'd1;
            end
            WR: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                done_d = 1'b1;
                rdata_d = wr_q ? rdata : lane_load;
            end
            ERR: begin
                state_d = IDLE;
                err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            off_q <= '0;
            sz_q <= '0;
            wd_q <= '0;
            wr_q <= 1'b0;
            rdata <= '0;
            done <= 1'b0;
            addr_err <= 1'b0;
            busy <= 1'b0;
            mem_addr <= '0;
            mem_wr <= 1'b0;
            mem_din <= '0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            off_q <= off_d;
            sz_q <= sz_d;
            wd_q <= wd_d;
            wr_q <= wr_d;
            rdata <= rdata_d;
            done <= done_d;
            addr_err <= err_d;
            busy <= state_d != IDLE;
            mem_addr <= mem_addr_d;
            mem_wr <= state_d == WR;
            mem_din <= mem_din_d;
        end
    end
endmodule
